sel_stream_mux: RTL and testbench
=================================

SEL_STREAM_MUX -- requirements
Module: sel_stream_mux

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits (1..32).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter SELW, default 2, select width; SHALL equal ceil(log2(CHANNELS)).
REQ-004 Clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 nReset  in  1  asynchronous, active-low reset.
REQ-006 Clear  in  1  synchronous clear, active-high.
REQ-007 Control  in  SELW  channel select, used in fixed-select mode only.
REQ-008 in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  in  CHANNELS  per-channel data-valid.
REQ-010 in_ready  out  CHANNELS  per-channel accept, combinational.
REQ-011 out_data  out  WIDTH  registered output data.
REQ-012 out_valid  out  1  output register holds an undelivered word.
REQ-013 out_ready  in  1  downstream accepts out_data.
REQ-014 out_sel  out  SELW  index of the channel that supplied out_data.

Function
REQ-015 The block SHALL have a single output register stage: empty (out_valid=0) or full (out_valid=1).
REQ-016 Grant g: exactly one channel or none, computed combinationally per cycle (REQ-030/031).
REQ-017 in_ready[g] SHALL be 1 iff grant exists, Clear=0, and (out_valid=0 or out_ready=1); all other in_ready bits 0.
REQ-018 Load: in_valid[g]&in_ready[g] SHALL, at the next edge, set out_data=in_data[g], out_sel=g, out_valid=1.
REQ-019 Drain: out_valid&out_ready with no load SHALL clear out_valid at the next edge; out_data and out_sel hold.
REQ-020 Simultaneous drain and load SHALL replace the word with out_valid staying 1; sustained throughput 1 word/cycle.
REQ-021 Latency from accepted input to out_valid SHALL be exactly 1 cycle.
REQ-022 out_data/out_sel SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 No grant (no eligible valid channel) SHALL produce no load; drain proceeds normally.
REQ-024 Clear=1 SHALL at the next edge force out_valid=0, out_data=0, out_sel=0, RR pointer=CHANNELS-1; Clear overrides load and drain.
REQ-025 During the Clear cycle all in_ready SHALL be 0, so no input word is consumed.

Reset
REQ-026 nReset=0 SHALL immediately, independent of Clock, force out_valid=0, out_data=0, out_sel=0, RR pointer=CHANNELS-1.
REQ-027 While nReset=0 all in_ready SHALL be 0.
REQ-028 Reset deassertion SHALL be synchronised by the integrator; first load is allowed on the first edge after deassertion.
REQ-029 Assertion mid-transfer SHALL discard the held word with no partial output.

Configuration
REQ-030 Without macro SEL_STREAM_MUX_RR_EN: g=Control when Control<CHANNELS, else no grant; Control may change any cycle, no RR pointer exists.
REQ-031 With SEL_STREAM_MUX_RR_EN: Control ignored; g = first channel with in_valid=1 searching upward from (pointer+1) mod CHANNELS with wrap-around; pointer SHALL update to g only on a load.

Verification
REQ-032 Fixed mode, CHANNELS=4, Control=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_sel=2.
REQ-033 Fixed mode, out_valid=1, out_ready=0 for 3 cycles, ch1 valid -> in_ready=0 and out_data stable; out_ready=1 -> drain and load same edge, out_valid stays 1.
REQ-034 RR mode, all 4 in_valid=1, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3.
REQ-035 RR mode, pointer=3, only ch3 and ch1 valid -> grant ch1 (wrap), next grant ch3.
REQ-036 Clear=1 coincident with load of ch0=8'h3C -> next cycle out_valid=0, out_data=0, in_ready[0]=0 during Clear; data not consumed.
REQ-037 nReset pulsed low mid-cycle with out_valid=1 -> out_valid=0, out_data=0 immediately, before the next Clock edge.

Source files
------------

// File: rtl/sel_stream_mux.sv
// Selects one of CHANNELS valid/ready input streams into a single registered output stage.
// Define SEL_STREAM_MUX_RR_EN for round-robin arbitration; the default build uses Control as a fixed select.
module sel_stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic                      Clear,
  input  logic [SELW-1:0]           Control,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_sel
);

  logic            grant_vld;
  logic [SELW-1:0] grant;
  logic            accept_ok;
  logic            load;

`ifdef SEL_STREAM_MUX_RR_EN
  logic [SELW-1:0] rr_ptr;

  // Search starts one past the last loaded channel, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!grant_vld && in_valid[(int'(rr_ptr) + k) % CHANNELS]) begin
        grant_vld = 1'b1;
        grant     = SELW'((int'(rr_ptr) + k) % CHANNELS);
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rr_ptr <= SELW'(CHANNELS - 1);
    end else if (Clear) begin
      rr_ptr <= SELW'(CHANNELS - 1);
    end else if (load) begin
      rr_ptr <= grant;
    end
  end
`else
  always_comb begin
    grant_vld = (32'(Control) < CHANNELS);
    grant     = Control;
  end
`endif

  // Reset is folded in so no channel is ever told it was accepted while held in reset.
  assign accept_ok = nReset && grant_vld && !Clear && (!out_valid || out_ready);
  assign load      = accept_ok && in_valid[grant];

  always_comb begin
    in_ready = '0;
    if (accept_ok) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (Clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_sel   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sel_stream_mux.sv
// Scoreboard bench for sel_stream_mux (default parameters); covers the round-robin
// variant when SEL_STREAM_MUX_RR_EN is defined, otherwise fixed-select mode.
module tb_sel_stream_mux;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        Clear;
  logic [1:0]  Control;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [9:0] exp_q[$];

  sel_stream_mux #(.WIDTH(8), .CHANNELS(4), .SELW(2)) dut (
    .Clock(Clock), .nReset(nReset), .Clear(Clear), .Control(Control),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every delivered word must match the oldest expected load.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge Clock);
      if (nReset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_word: got data %0h sel %0d expected none", out_data, out_sel);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[7:0]));
          chk("out_sel", 32'(out_sel), 32'(e[9:8]));
        end
      end
    end
  end

  task automatic step(input logic [1:0] ctrl, input logic [3:0] vmask, input logic rdy,
                      input logic clr, input logic [3:0] exp_rdy, input logic exp_ov,
                      input logic chk_od, input logic [7:0] exp_od, input logic [1:0] exp_os,
                      input logic load, input logic [1:0] ld_sel, input logic [7:0] ld_data);
    Control   = ctrl;
    in_valid  = vmask;
    out_ready = rdy;
    Clear     = clr;
    if (load) in_data[int'(ld_sel)*8 +: 8] = ld_data;
    @(negedge Clock);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (chk_od) begin
      chk("out_data_hold", 32'(out_data), 32'(exp_od));
      chk("out_sel_hold", 32'(out_sel), 32'(exp_os));
    end
    @(posedge Clock);
    if (load) exp_q.push_back({ld_sel, ld_data});
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d);
    in_data[ch*8 +: 8] = d;
  endtask

  initial begin
    nReset = 1'b0; Clear = 1'b0; Control = 2'd2; in_valid = 4'b1111;
    in_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 4'b0000;
    @(negedge Clock);
    nReset = 1'b1;
    @(posedge Clock); #1;

`ifdef SEL_STREAM_MUX_RR_EN
    for (int k = 0; k < 8; k++)
      step(2'd2, 4'b1111, 1'b1, 1'b0, 4'(1 << (k % 4)), (k > 0), 1'b0, 8'h00, 2'd0,
           1'b1, 2'(k % 4), 8'(8'h10 + (k % 4)));
    step(2'd0, 4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 2'd1, 8'h11);
    step(2'd0, 4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 2'd3, 8'h13);
    step(2'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 8'h00);
    step(2'd0, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 8'h00);
    step(2'd0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 8'h00, 2'd0, 1'b1, 2'd0, 8'h10);
    step(2'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 8'h00);
`else
    // Basic load, then back-to-back loads with Control changing every cycle.
    step(2'd2, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd2, 8'hA5);
    step(2'd0, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 8'hA5, 2'd2, 1'b1, 2'd0, 8'h40);
    step(2'd3, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 2'd3, 8'h41);
    step(2'd1, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 2'd1, 8'h42);
    step(2'd1, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 8'h00);
    // Backpressure: held word stable, then drain and load on the same edge.
    step(2'd1, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd1, 8'h11);
    set_ch(1, 8'h22);
    for (int k = 0; k < 3; k++)
      step(2'd1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h11, 2'd1, 1'b0, 2'd0, 8'h00);
    step(2'd1, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 2'd1, 8'h22);
    step(2'd1, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h22, 2'd1, 1'b0, 2'd0, 8'h00);
    // Clear discards the held word and blocks the coincident load.
    step(2'd3, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd3, 8'h77);
    set_ch(0, 8'h3C);
    step(2'd0, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 8'h77, 2'd3, 1'b0, 2'd0, 8'h00);
    exp_q.delete();
    step(2'd0, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 8'h00, 2'd0, 1'b1, 2'd0, 8'h3C);
    step(2'd0, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 8'h00);
    // Asynchronous reset mid-cycle with a held word.
    step(2'd2, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2'd2, 8'h5A);
    #3 nReset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_sel", 32'(out_sel), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    in_valid = 4'b0000;
    @(negedge Clock);
    nReset = 1'b1;
    @(posedge Clock); #1;
    step(2'd1, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 8'h00, 2'd0, 1'b1, 2'd1, 8'h66);
    step(2'd1, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 8'h00);
`endif

    in_valid = 4'b0000;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
